// File: rtl/generic_sc_fifo_pkg.sv
// Purpose: width arithmetic shared by the single-clock FIFO family.
// Latency: none, elaboration-time constant functions only.
// Backpressure: not applicable, no datapath in this package.
package generic_sc_fifo_pkg;

    // Smallest e with 2**e >= value; 0 for value <= 1.
    function automatic int clog2_ceil(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Integer division rounded up.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int narrow_width(input int a_w, input int b_w);
        return (a_w < b_w) ? a_w : b_w;
    endfunction

    function automatic int wide_width(input int a_w, input int b_w);
        return (a_w < b_w) ? b_w : a_w;
    endfunction

    // Number of narrow lanes in one wide word.
    function automatic int width_ratio(input int a_w, input int b_w);
        return wide_width(a_w, b_w) / narrow_width(a_w, b_w);
    endfunction

    // Lane-select bits inside a wide word (0 when both widths match).
    function automatic int width_ext(input int a_w, input int b_w);
        return clog2_ceil(width_ratio(a_w, b_w));
    endfunction

    // Narrow lanes covered by one word of width port_w.
    function automatic int lane_units(input int port_w, input int a_w, input int b_w);
        return port_w / narrow_width(a_w, b_w);
    endfunction

endpackage

// File: rtl/generic_sc_fifo_status.sv
// Purpose: occupancy counter in narrow units, full/empty/usedw decode, sticky ovf/udf.
// Latency: flags decode the registered count, so they move one edge after the cause.
// Backpressure: full/empty gate the accept strobes computed by the parent.
module generic_sc_fifo_status
    import generic_sc_fifo_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int WR_UNITS   = 1,
    parameter int RD_UNITS   = 8,
    parameter int EXT_W      = 3,
    parameter int WR_USEDW_W = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  wr_acc_i,
    input  logic                  rd_acc_i,
    output logic [WR_USEDW_W-1:0] wr_usedw_o,
    output logic                  wr_full_o,
    output logic                  wr_empty_o,
    output logic [CNT_W-1:0]      rd_usedw_o,
    output logic                  rd_empty_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    localparam logic [CNT_W-1:0] CAP_N    = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] WR_STEP  = CNT_W'(WR_UNITS);
    localparam logic [CNT_W-1:0] RD_STEP  = CNT_W'(RD_UNITS);
    localparam logic [CNT_W-1:0] ROUND_UP = CNT_W'((1 << EXT_W) - 1);
    localparam int               RD_SHIFT = clog2_ceil(RD_UNITS);

    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_nxt;
    logic [CNT_W-1:0] n_round;

    // Next occupancy: add accepted write lanes, remove accepted read lanes.
    always_comb begin
        n_nxt = n_q;
        if (wr_acc_i) n_nxt = n_nxt + WR_STEP;
        if (rd_acc_i) n_nxt = n_nxt - RD_STEP;
    end

    // Count and sticky errors; flush overrides any same-cycle request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_q   <= '0;
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else if (flush_i) begin
            n_q   <= '0;
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            n_q <= n_nxt;
            if (wr_en_i && wr_full_o)  ovf_o <= 1'b1;
            if (rd_en_i && rd_empty_o) udf_o <= 1'b1;
        end
    end

    assign wr_full_o  = (CAP_N - n_q) < WR_STEP;
    assign rd_empty_o = n_q < RD_STEP;
    assign wr_empty_o = (n_q == '0);

    // Write side reports whole-or-partial wide words, so a half-assembled
    // upsize word still shows up as one used entry.
    assign n_round    = n_q + ROUND_UP;
    assign wr_usedw_o = WR_USEDW_W'(n_round >> EXT_W);
    assign rd_usedw_o = n_q >> RD_SHIFT;

endmodule

// File: rtl/generic_sc_width_adapter_fifo.sv
// Purpose: single-clock FIFO converting between power-of-two related write/read widths.
// Latency: 1 cycle write-to-read; read data is show-ahead from the head entry.
// Backpressure: writes refused while full, reads refused while empty (sticky ovf/udf).
// Option: GENERIC_SC_WIDTH_ADAPTER_FIFO_MSB_FIRST_EN mirrors lane order (first word in top lane).
module generic_sc_width_adapter_fifo
    import generic_sc_fifo_pkg::*;
#(
    parameter int  WR_DATA_W  = 32,
    parameter int  RD_DATA_W  = 256,
    parameter int  ADDR_W     = 8,
    localparam int NARROW_W   = narrow_width(WR_DATA_W, RD_DATA_W),
    localparam int RATIO      = width_ratio(WR_DATA_W, RD_DATA_W),
    localparam int EXT_W      = width_ext(WR_DATA_W, RD_DATA_W),
    localparam int WR_UNITS   = lane_units(WR_DATA_W, WR_DATA_W, RD_DATA_W),
    localparam int RD_UNITS   = lane_units(RD_DATA_W, WR_DATA_W, RD_DATA_W),
    localparam int CNT_W      = ADDR_W + EXT_W + 1,
    localparam int WR_USEDW_W = (WR_DATA_W < RD_DATA_W) ? ADDR_W + 1 : CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [WR_DATA_W-1:0]  wr_data_i,
    output logic [WR_USEDW_W-1:0] wr_usedw_o,
    output logic                  wr_full_o,
    output logic                  wr_empty_o,
    input  logic                  rd_en_i,
    output logic [RD_DATA_W-1:0]  rd_data_o,
    output logic [CNT_W-1:0]      rd_usedw_o,
    output logic                  rd_empty_o,
    output logic                  rd_full_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

`ifdef GENERIC_SC_WIDTH_ADAPTER_FIFO_MSB_FIRST_EN
    localparam bit LANE_MIRROR = 1'b1;
`else
    localparam bit LANE_MIRROR = 1'b0;
`endif

    localparam int PTR_W = CNT_W - 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [RATIO-1:0][NARROW_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] wr_word;
    logic [ADDR_W-1:0] rd_word;
    logic              wr_acc;
    logic              rd_acc;

    // Flush wins over both ports, so nothing is accepted in a flush cycle.
    assign wr_acc = wr_en_i & ~wr_full_o & ~flush_i;
    assign rd_acc = rd_en_i & ~rd_empty_o & ~flush_i;

    // Pointers count narrow lanes; the upper bits pick the wide word.
    assign wr_word = ADDR_W'(wr_ptr >> EXT_W);
    assign rd_word = ADDR_W'(rd_ptr >> EXT_W);

    // Pointers advance by the port's lane count per beat and wrap at capacity.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(WR_UNITS);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(RD_UNITS);
        end
    end

    // Each port is either one lane wide or a whole word wide. Only the
    // narrow side applies the optional mirror, so the wide side always
    // sees lanes in their stored bit positions.
    generate
        if (WR_UNITS == RATIO) begin : g_wr_wide
            // Whole-word write covers every lane of the addressed entry.
            always_ff @(posedge clk_i) begin
                if (wr_acc) mem[wr_word] <= wr_data_i;
            end
        end else begin : g_wr_narrow
            logic [EXT_W-1:0] wr_lane;
            assign wr_lane = EXT_W'(wr_ptr);
            // Single-lane write into the partially assembled wide entry.
            always_ff @(posedge clk_i) begin
                if (wr_acc) mem[wr_word][LANE_MIRROR ? ~wr_lane : wr_lane] <= wr_data_i;
            end
        end

        if (RD_UNITS == RATIO) begin : g_rd_wide
            assign rd_data_o = mem[rd_word];
        end else begin : g_rd_narrow
            logic [EXT_W-1:0] rd_lane;
            assign rd_lane   = EXT_W'(rd_ptr);
            assign rd_data_o = mem[rd_word][LANE_MIRROR ? ~rd_lane : rd_lane];
        end
    endgenerate

    generic_sc_fifo_status #(
        .CNT_W      (CNT_W),
        .WR_UNITS   (WR_UNITS),
        .RD_UNITS   (RD_UNITS),
        .EXT_W      (EXT_W),
        .WR_USEDW_W (WR_USEDW_W)
    ) u_status (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .wr_en_i    (wr_en_i),
        .rd_en_i    (rd_en_i),
        .wr_acc_i   (wr_acc),
        .rd_acc_i   (rd_acc),
        .wr_usedw_o (wr_usedw_o),
        .wr_full_o  (wr_full_o),
        .wr_empty_o (wr_empty_o),
        .rd_usedw_o (rd_usedw_o),
        .rd_empty_o (rd_empty_o),
        .ovf_o      (ovf_o),
        .udf_o      (udf_o)
    );

    assign rd_full_o = wr_full_o;

endmodule
